inv_shiftrows_stream: RTL and testbench

Byte-serial AES InvShiftRows stage for the decryption datapath. It accepts a 128-bit state as 16 bytes on a valid/ready stream and buffers each complete state. It then emits the same 16 bytes permuted by InvShiftRows, the inverse of the encryption-side ShiftRows. Two ping-pong banks sustain one byte per cycle in each direction, so the block sits between the byte-serial AddRoundKey/InvSubBytes stages without stalling them.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/inv_shiftrows_stream.sv | 107 ++++++++++
 tb/tb_inv_shiftrows_stream.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, block size and the (Inv)ShiftRows
// byte-index permutations for a column-major, byte-serial state.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [7:0] aes_byte_t;

  // Per-bank occupancy: EMPTY while filling or idle, FULL while draining.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  // Source index for output byte k of InvShiftRows. Byte k sits at
  // row k[1:0], column k[3:2]; row r rotates right by r columns, so the
  // source column is (c - r) mod 4, which 2-bit arithmetic wraps for free.
  function automatic logic [3:0] inv_shiftrows_idx(input logic [3:0] k);
    logic [1:0] row;
    logic [1:0] src_col;
    row     = k[1:0];
    src_col = k[3:2] - row;
    return {src_col, row};
  endfunction

  // Source index for output byte k of ShiftRows (encryption side):
  // row r rotates left by r columns, source column is (c + r) mod 4.
  function automatic logic [3:0] shiftrows_idx(input logic [3:0] k);
    logic [1:0] row;
    logic [1:0] src_col;
    row     = k[1:0];
    src_col = k[3:2] + row;
    return {src_col, row};
  endfunction

endpackage

// File: rtl/inv_shiftrows_stream.sv
// Byte-serial AES InvShiftRows stage. Two ping-pong 16-byte banks: one
// fills from the input stream while the other drains permuted bytes, so
// both sides sustain one byte per cycle.
module inv_shiftrows_stream
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready
);

  localparam logic [3:0] LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

  aes_byte_t   r_mem [2][AES_BLOCK_BYTES];
  bank_state_t r_state [2];
  bank_state_t w_state_nxt [2];

  logic       r_wr_bank;
  logic [3:0] r_wr_cnt;
  logic       r_rd_bank;
  logic [3:0] r_rd_cnt;

  logic w_wr_fire;
  logic w_rd_fire;
  logic w_wr_last;
  logic w_rd_last;

  // Handshake qualifiers come only from registered bank state, so there is
  // no combinational path from in_valid/out_ready to in_ready/out_valid.
  assign in_ready  = (r_state[r_wr_bank] == BANK_EMPTY);
  assign out_valid = (r_state[r_rd_bank] == BANK_FULL);
  assign out_last  = out_valid && (r_rd_cnt == LAST_IDX);
  assign out_data  = r_mem[r_rd_bank][inv_shiftrows_idx(r_rd_cnt)];

  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_wr_last = (r_wr_cnt == LAST_IDX);
  assign w_rd_last = (r_rd_cnt == LAST_IDX);

  // Next bank states: fill completion and drain completion act on
  // different banks (write needs EMPTY, read needs FULL), so both apply.
  always_comb begin
    // NOTE: copy the current state first so every path assigns every
    // element; a missing default here would infer a latch.
    w_state_nxt = r_state;
    if (w_wr_fire && w_wr_last) begin
      w_state_nxt[r_wr_bank] = BANK_FULL;
    end
    if (w_rd_fire && w_rd_last) begin
      w_state_nxt[r_rd_bank] = BANK_EMPTY;
    end
  end

  // Bank state registers; reset discards any partial or full block.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_state[0] <= BANK_EMPTY;
      r_state[1] <= BANK_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fill pointer: advance per accepted byte, switch banks after byte 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else if (w_wr_fire) begin
      r_wr_cnt <= r_wr_cnt + 4'd1;
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Drain pointer: advance per accepted output byte, switch banks after 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else if (w_rd_fire) begin
      r_rd_cnt <= r_rd_cnt + 4'd1;
      if (w_rd_last) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Bank storage: write accepted input bytes in arrival order.
  always_ff @(posedge clk) begin
    // NOTE: the data banks are deliberately not reset; the full flags
    // gate every read, so stale contents are never observed.
    if (w_wr_fire) begin
      r_mem[r_wr_bank][r_wr_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_inv_shiftrows_stream.sv
// Directed and randomised bench for inv_shiftrows_stream with a byte
// queue model of the expected InvShiftRows output stream.
module tb_inv_shiftrows_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  int total;
  int bad;
  int out_cnt;

  logic [7:0] in_q  [$];
  logic [7:0] exp_q [$];

  // Hand-computed InvShiftRows of bytes 0x00..0x0F.
  logic [7:0] exp_single [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07,
                                  8'h04, 8'h01, 8'h0E, 8'h0B,
                                  8'h08, 8'h05, 8'h02, 8'h0F,
                                  8'h0C, 8'h09, 8'h06, 8'h03};

  inv_shiftrows_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // Queue one input block and its InvShiftRows image.
  task automatic push_block(input logic [7:0] blk [16]);
    for (int k = 0; k < 16; k++) in_q.push_back(blk[k]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        exp_q.push_back(blk[4 * ((c + 4 - r) % 4) + r]);
  endtask

  task automatic push_counting_block(input int base);
    logic [7:0] blk [16];
    for (int k = 0; k < 16; k++) blk[k] = 8'(base + k);
    push_block(blk);
  endtask

  // One clock cycle: drive at the falling edge, predict handshakes from the
  // values the next rising edge will see, and check every accepted output.
  task automatic cycle_traffic(input bit iv_en, input bit ordy);
    logic [7:0] exp_b;
    @(negedge clk);
    in_valid  = iv_en && (in_q.size() > 0);
    in_data   = (in_q.size() > 0) ? in_q[0] : 8'h00;
    out_ready = ordy;
    #1;
    if (in_valid && in_ready) void'(in_q.pop_front());
    if (out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_extra: got byte %02h, expected no output", out_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (out_data !== exp_b) begin
          bad++;
          $display("FAIL out_data[%0d]: got %02h, expected %02h", out_cnt, out_data, exp_b);
        end
      end
      total++;
      if (out_last !== ((out_cnt % 16) == 15)) begin
        bad++;
        $display("FAIL out_last[%0d]: got %b, expected %b", out_cnt, out_last, ((out_cnt % 16) == 15));
      end
      out_cnt++;
    end
  endtask

  // Run until both queues drain or the cycle budget expires.
  task automatic run_traffic(input int p_in, input int p_out, input int budget, input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0) && cyc < budget) begin
      cycle_traffic($urandom_range(99) < p_in, $urandom_range(99) < p_out);
      cyc++;
    end
    total++;
    if (exp_q.size() != 0 || in_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d inputs / %0d outputs left after %0d cycles, expected 0 / 0",
               name, in_q.size(), exp_q.size(), cyc);
    end
    cycle_traffic(0, 1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: out_valid=%b after drain, expected 0", name, out_valid);
    end
  endtask

  task automatic apply_reset(input bit check, input string name);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_q.delete(); exp_q.delete(); out_cnt = 0;
    if (check) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL %s_in_ready: got %b, expected 1", name, in_ready);
      end
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL %s_out_valid: got %b, expected 0", name, out_valid);
      end
      total++;
      if (out_last !== 1'b0) begin
        bad++; $display("FAIL %s_out_last: got %b, expected 0", name, out_last);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(1, "reset");
  endtask

  // Single block 0x00..0x0F with exact latency and framing.
  task automatic test_single_block();
    apply_reset(0, "single");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL single_fill[%0d]: out_valid=%b in_ready=%b, expected 0 1", i, out_valid, in_ready);
      end
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_single[j] || out_last !== (j == 15)) begin
        bad++;
        $display("FAIL single_out[%0d]: valid=%b data=%02h last=%b, expected 1 %02h %b",
                 j, out_valid, out_data, out_last, exp_single[j], (j == 15));
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_end: out_valid=%b, expected 0", out_valid);
    end
  endtask

  // Four back-to-back blocks: no input stall and no output bubble.
  task automatic test_back_to_back();
    int cyc, stalls, first_out, last_out, prev;
    apply_reset(0, "b2b");
    for (int b = 0; b < 4; b++) push_counting_block(16 * b);
    cyc = 0; stalls = 0; first_out = -1; last_out = -1;
    while (exp_q.size() > 0 && cyc < 400) begin
      prev = out_cnt;
      cycle_traffic(1, 1);
      if (in_valid && !in_ready) stalls++;
      if (out_cnt != prev) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      cyc++;
    end
    total++;
    if (stalls != 0) begin
      bad++; $display("FAIL b2b_stall: in_ready low %0d cycles, expected 0", stalls);
    end
    total++;
    if (out_cnt != 64 || last_out - first_out != 63) begin
      bad++;
      $display("FAIL b2b_span: %0d outputs over %0d cycles, expected 64 over 63", out_cnt, last_out - first_out);
    end
  endtask

  // Backpressure: two blocks fill, third stalls, output holds byte 0x00.
  task automatic test_backpressure();
    apply_reset(0, "bp");
    for (int b = 0; b < 3; b++) push_counting_block(16 * b);
    for (int i = 0; i < 40; i++) cycle_traffic(1, 0);
    total++;
    if (in_ready !== 1'b0 || in_q.size() != 16) begin
      bad++;
      $display("FAIL bp_full: in_ready=%b accepted=%0d, expected 0 32", in_ready, 48 - in_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || out_last !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%02h last=%b, expected 1 00 0", i, out_valid, out_data, out_last);
      end
      cycle_traffic(1, 0);
    end
    run_traffic(100, 100, 200, "bp");
  endtask

  task automatic test_random();
    logic [7:0] blk [16];
    apply_reset(0, "rand");
    for (int b = 0; b < 100; b++) begin
      for (int k = 0; k < 16; k++) blk[k] = 8'($urandom_range(255));
      push_block(blk);
    end
    run_traffic(50, 50, 20000, "rand");
  endtask

  // Reset after 8 input bytes, and after 6 output bytes, then a fresh block.
  task automatic test_reset_mid();
    apply_reset(0, "mid");
    push_counting_block(0);
    for (int i = 0; i < 8; i++) cycle_traffic(1, 1);
    apply_reset(1, "mid_fill");
    push_counting_block(0);
    for (int i = 0; i < 17; i++) cycle_traffic(1, 0);
    for (int i = 0; i < 6; i++) cycle_traffic(0, 1);
    apply_reset(1, "mid_drain");
    push_counting_block(0);
    run_traffic(100, 100, 100, "mid_fresh");
  endtask

  // Byte-serial ShiftRows output of a random state must come back unchanged.
  task automatic test_cascade();
    logic [7:0] s [16];
    apply_reset(0, "cascade");
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 16; k++) s[k] = 8'($urandom_range(255));
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          in_q.push_back(s[4 * ((c + r) % 4) + r]);
      for (int k = 0; k < 16; k++) exp_q.push_back(s[k]);
    end
    run_traffic(100, 100, 200, "cascade");
  endtask

  initial begin
    total = 0; bad = 0; out_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
